// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch buffer entry type.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO with flush; push and pop may coincide even when full.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

    assign valid = (count_q != '0);
    assign rdata = valid ? mem[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, credit-limited memory requests, prefetch buffer, redirect flush.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);

    localparam int unsigned CW   = $clog2(2*DEPTH) + 1;
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   pending_q, pending_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CNTW-1:0] count;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] target_pc;
    logic            accept, push, pop, drop_hit;
    fetch_entry_t    wentry, rentry;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign target_pc = {redirect_pc[31:2], 2'b00};

    // Buffered plus outstanding-but-wanted words must never exceed the FIFO size.
    assign in_use = (CW+1)'(count) + (CW+1)'(pending_q) - (CW+1)'(drop_q);

    assign imem_req_valid = reset && !halt && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign drop_hit = (drop_q != '0);
    assign push     = imem_resp_valid && !drop_hit && !redirect_valid;
    assign pop      = inst_valid && inst_ready && !redirect_valid;
    assign wentry   = '{pc: resp_pc_q, data: imem_resp_data};

    always_comb begin
        pending_d  = pending_q + CW'(accept) - CW'(imem_resp_valid);
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            drop_d     = pending_q - CW'(imem_resp_valid);
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
        end else begin
            if (imem_resp_valid && drop_hit) drop_d = drop_q - 1'b1;
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
            if (push)   resp_pc_d  = resp_pc_q + XLEN'(INST_BYTES);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            pending_q  <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (rentry),
        .valid (inst_valid),
        .count (count)
    );

    assign inst_pc   = rentry.pc;
    assign inst_data = rentry.data;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          total = 0;
    int          fails = 0;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present this cycle's memory response, then let combinational outputs settle.
    task automatic settle();
        if (reset && q.size() > 0 && q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word(q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic adv();
        logic        acc;
        logic [31:0] a;
        logic        rv;
        logic        ok;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rv  = imem_resp_valid;
        if (inst_valid && inst_ready && !redirect_valid) pop_log.push_back(inst_pc);
        @(posedge clk);
        cyc++;
        if (rv) void'(q.pop_front());
        if (acc) begin
            q.push_back('{addr: a, due: cyc + lat - 1});
            acc_log.push_back(a);
        end
        @(negedge clk);
        ok = (dut.drop_q <= dut.pending_q) && (dut.pending_q <= 4'd8) && (dut.count <= 3'd4);
        chk("invariant", {31'b0, ok}, 32'd1);
    endtask

    task automatic cycle();
        settle();
        adv();
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n;
        n = 0;
        settle();
        while (!inst_valid && n < max) begin
            adv();
            settle();
            n++;
        end
        chk(tag, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        halt            = 1'b0;
        imem_resp_valid = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        acc_log.delete();
        pop_log.delete();
    endtask

    initial begin
        int          exp_drop;
        int          n;
        logic        seen_req;
        logic [31:0] tmp;

        reset           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        halt            = 1'b0;
        #1;
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Streaming, latency 1, decode always ready.
        lat = 1;
        do_reset();
        settle();
        chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'h0);
        adv();
        settle();
        chk("t1_no_bypass", {31'b0, inst_valid}, 32'd0);
        adv();
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t1_valid", {31'b0, inst_valid}, 32'd1);
            chk("t1_pc", inst_pc, 32'(4 * i));
            chk("t1_data", inst_data, word(32'(4 * i)));
            adv();
        end

        // Decode stalled: credit limits fetch to DEPTH words.
        inst_ready = 1'b0;
        do_reset();
        repeat (12) cycle();
        chk("t2_req_count", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            tmp = (acc_log.size() > i) ? acc_log[i] : 32'hxxxx_xxxx;
            chk("t2_req_addr", tmp, 32'(4 * i));
        end
        settle();
        chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_fifo_count", 32'(dut.count), 32'd4);
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid("t2_wait", 10);
            chk("t2_pop_pc", inst_pc, 32'(4 * i));
            adv();
        end
        tmp = (acc_log.size() > 4) ? acc_log[4] : 32'hxxxx_xxxx;
        chk("t2_resume_addr", tmp, 32'h10);

        // Redirect with three requests outstanding at latency 3.
        lat = 3;
        do_reset();
        n = 0;
        while (acc_log.size() < 5 && n < 30) begin
            cycle();
            n++;
        end
        chk("t3_setup", 32'(acc_log.size()), 32'd5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        settle();
        exp_drop = q.size() - (imem_resp_valid ? 1 : 0);
        chk("t3_no_req_redirect", {31'b0, imem_req_valid}, 32'd0);
        adv();
        redirect_valid = 1'b0;
        chk("t3_drop", 32'(dut.drop_q), 32'(exp_drop));
        settle();
        chk("t3_req_addr", imem_req_addr, 32'h100);
        wait_valid("t3_wait", 20);
        chk("t3_pc", inst_pc, 32'h100);
        chk("t3_data", inst_data, word(32'h100));
        adv();

        // Misaligned redirect target, latency 1.
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        settle();
        adv();
        redirect_valid = 1'b0;
        settle();
        chk("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        wait_valid("t4_wait", 20);
        chk("t4_pc", inst_pc, 32'h200);
        chk("t4_data", inst_data, word(32'h200));

        // Halt with two requests in flight.
        lat = 3;
        do_reset();
        n = 0;
        while (acc_log.size() < 2 && n < 10) begin
            cycle();
            n++;
        end
        halt = 1'b1;
        pop_log.delete();
        seen_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (imem_req_valid) seen_req = 1'b1;
            adv();
        end
        chk("t5_req_held", {31'b0, seen_req}, 32'd0);
        chk("t5_pop_count", 32'(pop_log.size()), 32'd2);
        tmp = (pop_log.size() > 0) ? pop_log[0] : 32'hxxxx_xxxx;
        chk("t5_pop0", tmp, 32'h0);
        tmp = (pop_log.size() > 1) ? pop_log[1] : 32'hxxxx_xxxx;
        chk("t5_pop1", tmp, 32'h4);
        halt = 1'b0;
        settle();
        chk("t5_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t5_resume_addr", imem_req_addr, 32'h8);

        // Asynchronous reset in the middle of a cycle.
        inst_ready = 1'b0;
        do_reset();
        n = 0;
        while (dut.count != 3'd3 && n < 20) begin
            cycle();
            n++;
        end
        settle();
        chk("t6_setup_count", 32'(dut.count), 32'd3);
        reset = 1'b0;
        #1;
        chk("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("t6_inst_pc", inst_pc, 32'h0);
        chk("t6_inst_data", inst_data, 32'h0);
        chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t6_pending", 32'(dut.pending_q), 32'd0);
        q.delete();
        imem_resp_valid = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        inst_ready = 1'b1;
        lat        = 1;
        settle();
        chk("t6_restart_addr", imem_req_addr, 32'h0);
        wait_valid("t6_wait", 10);
        chk("t6_restart_pc", inst_pc, 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits upstream of decode and the register file. It owns the architectural PC and issues word reads to an instruction memory with variable latency over a valid/ready request and in-order response interface.
- Fetched words are buffered in a small prefetch FIFO and presented to decode as (pc, instruction) pairs.
- Branch/jump redirects flush the buffer and drop any in-flight stale responses.

Parameters:
- DEPTH, 4: prefetch FIFO entries; must be a power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_resp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head is valid.
- inst_ready  in  1  decode consumes the head.
- inst_pc  out  32  PC of the head instruction.
- inst_data  out  32  head instruction word.
- redirect_valid  in  1  branch/jal/jalr taken; the flush takes priority over everything else.
- redirect_pc  in  32  new fetch target; bits [1:0] are cleared internally.
- halt  in  1  stop issuing new requests (ecall with x17==10).

Behaviour:
- State:
  - fetch_pc (32)
  - resp_pc (32): PC of the next non-stale response
  - pending (clog2(2*DEPTH)+1 bits): accepted requests not yet answered
  - drop (same width): stale responses still to discard
  - FIFO of DEPTH {pc, data} entries with count
- Reset (reset==0, asynchronous):
  - fetch_pc=resp_pc=RESET_PC; pending=drop=count=0.
  - inst_valid=0, inst_pc=0, inst_data=0, imem_req_valid=0.
  - A reset asserted mid-operation discards all in-flight transactions. The memory must also be reset; responses arriving while reset==0 are ignored.
- Request issue:
  - imem_req_valid = reset && !halt && !redirect_valid && (count + pending - drop < DEPTH). This credit rule guarantees the FIFO never overflows.
  - imem_req_addr = fetch_pc.
  - On accept (valid&&ready): fetch_pc += 4 (wraps modulo 2^32), pending += 1.
- Response:
  - On imem_resp_valid: pending -= 1.
  - If drop>0: drop -= 1 and the word is discarded.
  - Otherwise push {resp_pc, imem_resp_data} and resp_pc += 4.
- Output:
  - inst_* shows the FIFO head.
  - Latency from response to inst_valid is 1 cycle (no bypass).
  - Pop occurs on inst_valid && inst_ready.
  - Push and pop in the same cycle are allowed at any count, including full.
- Redirect (redirect_valid=1), taking effect at the next edge:
  - fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}; count=0.
  - drop = pending - (imem_resp_valid ? 1 : 0), i.e. all remaining in-flight requests are stale.
  - A response arriving in the redirect cycle is discarded.
  - A pop (inst_ready) in the redirect cycle is ignored; decode must not commit it.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects are legal; each recomputes drop from the current pending.
- Halt: no new requests while halt=1. In-flight responses are still accepted and buffered, and the FIFO keeps draining. Deasserting halt resumes at fetch_pc.
- Counter invariants, checked by bench assertions:
  - drop ≤ pending ≤ 2*DEPTH
  - count ≤ DEPTH
  - imem_resp_valid with pending==0 is a protocol error.

Decomposition:
- Shared package (cpu_pkg): XLEN=32 and INST_BYTES=4 constants, plus a fetch_entry_t struct {pc, data}.
- Sub-module fetch_fifo: a parameterised synchronous FIFO with push, pop, flush and count outputs, and an asynchronous active-low reset.
- The credit, drop and PC logic stays in fetch_unit.

Test Plan:
- Reset release, memory ready=1 and 1-cycle latency, inst_ready=1 → inst_pc sequence 0,4,8,12… with data matching the memory words, one instruction per cycle in steady state.
- inst_ready=0 with DEPTH=4 → exactly 4 requests issued (addresses 0,4,8,12), then imem_req_valid=0 and count=4. Raising inst_ready pops 0,4,8,12, then fetch resumes at 16.
- Memory latency 3 with 3 requests outstanding (pc 8,12,16); redirect_pc=0x100 → drop=3 (or 2 if a response coincides). None of 8/12/16 reaches decode, and the next inst_pc is 0x100.
- Redirect with redirect_pc=0x203 → imem_req_addr=0x200 and inst_pc=0x200.
- halt=1 with 2 requests in flight → both words delivered and imem_req_valid held at 0. Dropping halt issues the next sequential address.
- reset pulsed low mid-stream (count=3, pending=2) → outputs clear asynchronously in the same cycle, and after release fetch restarts at RESET_PC.
